// File: rtl/pipeline_if.sv
// Instruction-fetch stage: issues sequential fetches over a req/gnt + rvalid memory port,
// buffers returned words in order with their PCs, and hands one instruction per cycle to decode.
module pipeline_if #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] NOP_INST = 'h13
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] last_pc;
  logic [XLEN-1:0] buf_pc   [DEPTH];
  logic [XLEN-1:0] buf_inst [DEPTH];
  logic [DEPTH-1:0] buf_filled;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [PW-1:0]   fill_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   pend;
  logic [CW-1:0]   drop_cnt;

  logic            head_valid;
  logic            credit_ok;
  logic            issue;
  logic            pop;
  logic            resp_drop;
  logic            resp_fill;
  logic [CW:0]     outstanding_next;
  logic [1:0]      unused_redirect_lsbs;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Filled entries always form a prefix starting at head, since responses return in order;
  // fill_ptr marks the oldest unfilled entry and pend counts entries still waiting for data.
  assign head_valid = (count != '0) && buf_filled[head];
  assign credit_ok  = ({1'b0, count} + {1'b0, drop_cnt}) < (CW + 1)'(DEPTH);
  assign imem_req   = !rst && !redirect_valid && credit_ok;
  assign imem_addr  = fetch_pc;
  assign issue      = imem_req && imem_gnt;
  assign pop        = head_valid && !stall && !redirect_valid;
  assign resp_drop  = imem_rvalid && (drop_cnt != '0);
  assign resp_fill  = imem_rvalid && (drop_cnt == '0) && (pend != '0);

  assign outstanding_next = {1'b0, drop_cnt} + {1'b0, pend} - (CW + 1)'(resp_drop || resp_fill);
  assign unused_redirect_lsbs = redirect_pc[1:0];

  assign inst_valid = !rst && head_valid;
  assign inst       = inst_valid ? buf_inst[head] : NOP_INST;
  assign pc         = rst ? '0 : (inst_valid ? buf_pc[head] : last_pc);

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc   <= RESET_PC;
      last_pc    <= '0;
      head       <= '0;
      tail       <= '0;
      fill_ptr   <= '0;
      count      <= '0;
      pend       <= '0;
      drop_cnt   <= '0;
      buf_filled <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_pc[i]   <= '0;
        buf_inst[i] <= '0;
      end
    end else begin
      if (head_valid) begin
        last_pc <= buf_pc[head];
      end
      // Redirect squashes everything buffered; whatever is still at memory becomes a drop.
      if (redirect_valid) begin
        fetch_pc   <= {redirect_pc[XLEN-1:2], 2'b00};
        head       <= '0;
        tail       <= '0;
        fill_ptr   <= '0;
        count      <= '0;
        pend       <= '0;
        buf_filled <= '0;
        drop_cnt   <= CW'(outstanding_next);
      end else begin
        if (issue) begin
          buf_pc[tail]     <= fetch_pc;
          buf_filled[tail] <= 1'b0;
          tail             <= next_ptr(tail);
          fetch_pc         <= fetch_pc + XLEN'(4);
        end
        if (resp_fill) begin
          buf_inst[fill_ptr]   <= imem_rdata;
          buf_filled[fill_ptr] <= 1'b1;
          fill_ptr             <= next_ptr(fill_ptr);
        end
        if (pop) begin
          head <= next_ptr(head);
        end
        count    <= count + CW'(issue) - CW'(pop);
        pend     <= pend + CW'(issue) - CW'(resp_fill);
        drop_cnt <= drop_cnt - CW'(resp_drop);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_if.sv
// Directed bench for pipeline_if: an in-order memory model with programmable latency and grant
// pattern feeds the fetch stage while each task checks the stream seen by decode.
module tb_pipeline_if;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] pc;

  int cmp_count = 0;
  int err_count = 0;

  int          mem_lat = 1;
  bit          gnt_mode = 1'b0;
  int          cyc = 0;
  logic [31:0] pend_q[$];
  int          due_q[$];
  int          max_inflight = 0;
  int          addr_hold_err = 0;
  bit          prev_ungr = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] exp_pc = '0;

  pipeline_if dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .pc(pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h0013_0000;
  endfunction

  // Memory model: records grants at the rising edge, drives gnt/rvalid/rdata at the falling edge.
  always begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      pend_q.delete();
      due_q.delete();
      prev_ungr = 1'b0;
    end else begin
      if (imem_rvalid && pend_q.size() > 0) begin
        void'(pend_q.pop_front());
        void'(due_q.pop_front());
      end
      if (prev_ungr && imem_req && imem_addr !== prev_addr) addr_hold_err++;
      prev_ungr = imem_req && !imem_gnt;
      prev_addr = imem_addr;
      if (imem_req && imem_gnt) begin
        pend_q.push_back(imem_addr);
        due_q.push_back(cyc + mem_lat);
      end
      if (pend_q.size() > max_inflight) max_inflight = pend_q.size();
    end
    @(negedge clk);
    imem_gnt = gnt_mode ? (cyc % 3 != 2) : 1'b1;
    if (pend_q.size() > 0 && due_q[0] <= cyc + 1) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend_q[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    cmp_count++; if (inst_valid !== 1'b0) begin err_count++; $display("[TB] FAIL reset_inst_valid: got %b want 0", inst_valid); end
    cmp_count++; if (inst !== 32'h13) begin err_count++; $display("[TB] FAIL reset_inst: got %h want 00000013", inst); end
    cmp_count++; if (pc !== 32'h0) begin err_count++; $display("[TB] FAIL reset_pc: got %h want 0", pc); end
    cmp_count++; if (imem_req !== 1'b0) begin err_count++; $display("[TB] FAIL reset_req: got %b want 0", imem_req); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    cmp_count++; if (imem_req !== 1'b1) begin err_count++; $display("[TB] FAIL release_req: got %b want 1", imem_req); end
    cmp_count++; if (imem_addr !== 32'h0) begin err_count++; $display("[TB] FAIL release_addr: got %h want 0", imem_addr); end
  endtask

  task automatic test_stream();
    int n = 0;
    int first = -1;
    exp_pc = 32'h0;
    for (int i = 1; i <= 40 && n < 8; i++) begin
      @(negedge clk); #1;
      if (inst_valid === 1'b1) begin
        if (first < 0) first = i;
        cmp_count++; if (pc !== exp_pc) begin err_count++; $display("[TB] FAIL stream_pc: got %h want %h", pc, exp_pc); end
        cmp_count++; if (inst !== mem_word(exp_pc)) begin err_count++; $display("[TB] FAIL stream_inst: got %h want %h", inst, mem_word(exp_pc)); end
        exp_pc += 4;
        n++;
      end
    end
    cmp_count++; if (first != 2) begin err_count++; $display("[TB] FAIL stream_first_valid_cycle: got %0d want 2", first); end
    cmp_count++; if (n != 8) begin err_count++; $display("[TB] FAIL stream_count: got %0d want 8", n); end
  endtask

  task automatic test_stall();
    int n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      stall = 1'b1;
      #1;
      if (inst_valid === 1'b1) begin
        cmp_count++; if (pc !== exp_pc) begin err_count++; $display("[TB] FAIL stall_pc_frozen: got %h want %h", pc, exp_pc); end
        cmp_count++; if (inst !== mem_word(exp_pc)) begin err_count++; $display("[TB] FAIL stall_inst_frozen: got %h want %h", inst, mem_word(exp_pc)); end
      end
    end
    cmp_count++; if (imem_req !== 1'b0) begin err_count++; $display("[TB] FAIL stall_req_full: got %b want 0", imem_req); end
    cmp_count++; if (inst_valid !== 1'b1) begin err_count++; $display("[TB] FAIL stall_head_valid: got %b want 1", inst_valid); end
    for (int i = 0; i < 30 && n < 6; i++) begin
      @(negedge clk);
      stall = 1'b0;
      #1;
      if (inst_valid === 1'b1) begin
        cmp_count++; if (pc !== exp_pc) begin err_count++; $display("[TB] FAIL resume_pc: got %h want %h", pc, exp_pc); end
        cmp_count++; if (inst !== mem_word(exp_pc)) begin err_count++; $display("[TB] FAIL resume_inst: got %h want %h", inst, mem_word(exp_pc)); end
        exp_pc += 4;
        n++;
      end
    end
    cmp_count++; if (n != 6) begin err_count++; $display("[TB] FAIL resume_count: got %0d want 6", n); end
  endtask

  task automatic test_redirect();
    bit fired = 1'b0;
    int n = 0;
    mem_lat = 3;
    for (int i = 0; i < 40 && !fired; i++) begin
      @(negedge clk); #1;
      if (pend_q.size() == 2) begin
        redirect_valid = 1'b1;
        redirect_pc = 32'h103;
        fired = 1'b1;
        #1;
        cmp_count++; if (imem_req !== 1'b0) begin err_count++; $display("[TB] FAIL redirect_req_low: got %b want 0", imem_req); end
      end
      if (inst_valid === 1'b1) begin
        cmp_count++; if (pc !== exp_pc) begin err_count++; $display("[TB] FAIL pre_redirect_pc: got %h want %h", pc, exp_pc); end
        if (!fired) exp_pc += 4;
      end
    end
    cmp_count++; if (!fired) begin err_count++; $display("[TB] FAIL redirect_setup: got no 2-deep in-flight want 2"); end
    @(negedge clk);
    redirect_valid = 1'b0;
    exp_pc = 32'h100;
    #1;
    cmp_count++; if (inst_valid !== 1'b0) begin err_count++; $display("[TB] FAIL post_redirect_valid: got %b want 0", inst_valid); end
    cmp_count++; if (imem_addr !== 32'h100) begin err_count++; $display("[TB] FAIL post_redirect_addr: got %h want 00000100", imem_addr); end
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk); #1;
      if (inst_valid === 1'b1) begin
        cmp_count++; if (pc !== exp_pc) begin err_count++; $display("[TB] FAIL redirect_stream_pc: got %h want %h", pc, exp_pc); end
        cmp_count++; if (inst !== mem_word(exp_pc)) begin err_count++; $display("[TB] FAIL redirect_stream_inst: got %h want %h", inst, mem_word(exp_pc)); end
        exp_pc += 4;
        n++;
      end
    end
    cmp_count++; if (n != 4) begin err_count++; $display("[TB] FAIL redirect_stream_count: got %0d want 4", n); end
  endtask

  task automatic test_intermittent();
    int n = 0;
    gnt_mode = 1'b1;
    mem_lat = 3;
    max_inflight = 0;
    addr_hold_err = 0;
    for (int i = 0; i < 120 && n < 10; i++) begin
      @(negedge clk); #1;
      if (inst_valid === 1'b1) begin
        cmp_count++; if (pc !== exp_pc) begin err_count++; $display("[TB] FAIL slow_pc: got %h want %h", pc, exp_pc); end
        cmp_count++; if (inst !== mem_word(exp_pc)) begin err_count++; $display("[TB] FAIL slow_inst: got %h want %h", inst, mem_word(exp_pc)); end
        exp_pc += 4;
        n++;
      end
    end
    cmp_count++; if (n != 10) begin err_count++; $display("[TB] FAIL slow_count: got %0d want 10", n); end
    cmp_count++; if (addr_hold_err != 0) begin err_count++; $display("[TB] FAIL slow_addr_hold: got %0d changes want 0", addr_hold_err); end
    cmp_count++; if (max_inflight != 2) begin err_count++; $display("[TB] FAIL slow_max_inflight: got %0d want 2", max_inflight); end
    gnt_mode = 1'b0;
    mem_lat = 1;
  endtask

  task automatic test_wrap();
    int n = 0;
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    @(negedge clk);
    redirect_valid = 1'b0;
    exp_pc = 32'hFFFF_FFFC;
    #1;
    cmp_count++; if (imem_addr !== 32'hFFFF_FFFC) begin err_count++; $display("[TB] FAIL wrap_addr: got %h want fffffffc", imem_addr); end
    for (int i = 0; i < 40 && n < 3; i++) begin
      @(negedge clk); #1;
      if (inst_valid === 1'b1) begin
        cmp_count++; if (pc !== exp_pc) begin err_count++; $display("[TB] FAIL wrap_pc: got %h want %h", pc, exp_pc); end
        cmp_count++; if (inst !== mem_word(exp_pc)) begin err_count++; $display("[TB] FAIL wrap_inst: got %h want %h", inst, mem_word(exp_pc)); end
        exp_pc += 4;
        n++;
      end
    end
    cmp_count++; if (n != 3) begin err_count++; $display("[TB] FAIL wrap_count: got %0d want 3", n); end
  endtask

  task automatic test_reset_midstream();
    int n = 0;
    int first = -1;
    mem_lat = 3;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      stall = 1'b1;
    end
    #1;
    cmp_count++; if (inst_valid !== 1'b1) begin err_count++; $display("[TB] FAIL mid_full_valid: got %b want 1", inst_valid); end
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    rst = 1'b1;
    mem_lat = 1;
    @(negedge clk); #1;
    cmp_count++; if (inst_valid !== 1'b0) begin err_count++; $display("[TB] FAIL mid_reset_valid: got %b want 0", inst_valid); end
    cmp_count++; if (inst !== 32'h13) begin err_count++; $display("[TB] FAIL mid_reset_inst: got %h want 00000013", inst); end
    cmp_count++; if (imem_req !== 1'b0) begin err_count++; $display("[TB] FAIL mid_reset_req: got %b want 0", imem_req); end
    cmp_count++; if (pc !== 32'h0) begin err_count++; $display("[TB] FAIL mid_reset_pc: got %h want 0", pc); end
    @(negedge clk);
    rst = 1'b0;
    stall = 1'b0;
    #1;
    cmp_count++; if (imem_addr !== 32'h0) begin err_count++; $display("[TB] FAIL mid_release_addr: got %h want 0", imem_addr); end
    cmp_count++; if (imem_req !== 1'b1) begin err_count++; $display("[TB] FAIL mid_release_req: got %b want 1", imem_req); end
    exp_pc = 32'h0;
    for (int i = 1; i <= 30 && n < 3; i++) begin
      @(negedge clk); #1;
      if (inst_valid === 1'b1) begin
        if (first < 0) first = i;
        cmp_count++; if (pc !== exp_pc) begin err_count++; $display("[TB] FAIL mid_stream_pc: got %h want %h", pc, exp_pc); end
        cmp_count++; if (inst !== mem_word(exp_pc)) begin err_count++; $display("[TB] FAIL mid_stream_inst: got %h want %h", inst, mem_word(exp_pc)); end
        exp_pc += 4;
        n++;
      end
    end
    cmp_count++; if (first != 2) begin err_count++; $display("[TB] FAIL mid_first_valid_cycle: got %0d want 2", first); end
    cmp_count++; if (n != 3) begin err_count++; $display("[TB] FAIL mid_stream_count: got %0d want 3", n); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_intermittent();
    test_wrap();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
